avmm_image_responder: RTL
=========================

AVMM_IMAGE_RESPONDER -- requirements
Module: avmm_image_responder

Interface
REQ-001 Parameter DEPTH, default 4096, number of 64-bit words held (power of two, 16..65536).
REQ-002 Parameter BASE_ADDR, default 0, 64-bit byte address of word 0 (8-byte aligned).
REQ-003 Parameter READ_LATENCY, default 1, cycles from read request to readdata valid (legal 1..4).
REQ-004 Parameter POISON, default 64'hDEAD_BEEF_DEAD_BEEF, readdata returned for out-of-range reads.
REQ-005 clock  input  1  single clock; all logic on its rising edge.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 avmm_0_rw_address  input  64  byte address from the initiator.
REQ-008 avmm_0_rw_byteenable  input  8  per-byte write enable; bit i covers data bits [8i+7:8i].
REQ-009 avmm_0_rw_read  input  1  read request, one cycle per request.
REQ-010 avmm_0_rw_write  input  1  write request, one cycle per request.
REQ-011 avmm_0_rw_writedata  input  64  write data.
REQ-012 avmm_0_rw_readdata  output  64  read data, fixed latency.
REQ-013 avmm_0_rw_readdatavalid  output  1  high for one cycle when readdata carries a response (bench aid).
REQ-014 rd_count  output  32  accepted reads, saturating.
REQ-015 wr_count  output  32  accepted writes, saturating.
REQ-016 err_count  output  16  protocol/range errors, saturating.

Function
REQ-017 Word index SHALL be (address - BASE_ADDR) >> 3; in range iff 0 <= index < DEPTH, computed in full 64-bit unsigned arithmetic (address below BASE_ADDR is out of range, no wrap).
REQ-018 The responder SHALL never stall; every request is accepted the cycle it is presented (no waitrequest).
REQ-019 In-range write SHALL update only the bytes whose byteenable bit is 1, committed at the same clock edge.
REQ-020 Write with byteenable == 0 SHALL leave memory unchanged and still increment wr_count.
REQ-021 In-range read SHALL return the stored word on readdata exactly READ_LATENCY cycles after the request cycle, with readdatavalid high in that cycle only.
REQ-022 Read issued the cycle after a write to the same word SHALL return the newly written data.
REQ-023 Back-to-back reads every cycle SHALL each return in order at full throughput through a READ_LATENCY-deep pipeline.
REQ-024 Out-of-range read SHALL return POISON with readdatavalid, increment rd_count and err_count.
REQ-025 Out-of-range write SHALL be dropped, increment wr_count and err_count.
REQ-026 Address with bits [2:0] nonzero SHALL be served using the truncated word index and increment err_count once.
REQ-027 read and write high in the same cycle SHALL perform the write only, produce no read response, increment err_count once.
REQ-028 readdata SHALL hold its last value when readdatavalid is low.
REQ-029 Counters SHALL saturate at all-ones, never wrap; one request increments err_count at most once.

Reset
REQ-030 On reset: readdata = 0, readdatavalid = 0, rd_count = wr_count = err_count = 0, read pipeline flushed.
REQ-031 Reads in flight when reset asserts SHALL produce no response after reset.
REQ-032 Memory contents SHALL NOT be cleared by reset.
REQ-033 Requests presented while reset is high SHALL be ignored.

Structure
REQ-034 Shared package avmm_pkg SHALL hold data/address/byteenable widths, the POISON default and a request struct (address, byteenable, read, write, writedata).
REQ-035 One sub-module avmm_be_ram (DEPTH x 64 single-port RAM with byte-enable write, registered read) SHALL hold storage; latency beyond 1 is added in the top pipeline.

Verification
REQ-036 Write 64'h0123_4567_89AB_CDEF at BASE_ADDR+8 with be=8'hFF, read it -> 64'h0123_4567_89AB_CDEF after READ_LATENCY cycles, rd_count=1, wr_count=1.
REQ-037 Preload 64'hFFFF_FFFF_FFFF_FFFF, write 0 with be=8'h0F, read -> 64'hFFFF_FFFF_0000_0000.
REQ-038 Read address BASE_ADDR+8*DEPTH and BASE_ADDR-8 -> POISON twice, err_count=2.
REQ-039 Read and write asserted together at word 5 -> write lands, no readdatavalid, err_count=1.
REQ-040 READ_LATENCY=3, reads to words 0..7 on 8 consecutive cycles -> 8 in-order responses on cycles 3..10; reset asserted at cycle 4 -> no response after reset, counters 0.
REQ-041 Force rd_count to 32'hFFFF_FFFE, issue 3 reads -> rd_count stays 32'hFFFF_FFFF.

Source files
------------

// File: rtl/avmm_pkg.sv
// Shared widths, poison default and request bundle
// for the AVMM image responder.
package avmm_pkg;

  localparam int unsigned DATA_W = 64;
  localparam int unsigned ADDR_W = 64;
  localparam int unsigned BE_W   = 8;

  localparam logic [DATA_W-1:0] POISON_DEFAULT =
    64'hDEAD_BEEF_DEAD_BEEF;

  typedef struct packed {
    logic [ADDR_W-1:0] address;
    logic [BE_W-1:0]   byteenable;
    logic              read;
    logic              write;
    logic [DATA_W-1:0] writedata;
  } req_t;

  function automatic logic [31:0] sat_inc32(
    input logic [31:0] v,
    input logic        en
  );
    return (en && !(&v)) ? v + 32'd1 : v;
  endfunction

  function automatic logic [15:0] sat_inc16(
    input logic [15:0] v,
    input logic        en
  );
    return (en && !(&v)) ? v + 16'd1 : v;
  endfunction

endpackage

// File: rtl/avmm_image_responder_if.sv
// Avalon-MM read/write bus between initiator and
// the image responder.
interface avmm_image_responder_if;
  import avmm_pkg::*;

  logic [ADDR_W-1:0] address;
  logic [BE_W-1:0]   byteenable;
  logic              read;
  logic              write;
  logic [DATA_W-1:0] writedata;
  logic [DATA_W-1:0] readdata;
  logic              readdatavalid;

  modport master (
    output address, byteenable, read, write,
    output writedata,
    input  readdata, readdatavalid
  );

  modport slave (
    input  address, byteenable, read, write,
    input  writedata,
    output readdata, readdatavalid
  );

endinterface

// File: rtl/avmm_be_ram.sv
// Single-port 64-bit RAM, per-byte write enable,
// registered read port.
module avmm_be_ram
  import avmm_pkg::*;
#(
  parameter int unsigned DEPTH = 4096,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic              clk_i,
  input  logic              we_i,
  input  logic              re_i,
  input  logic [AW-1:0]     addr_i,
  input  logic [BE_W-1:0]   be_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      for (int b = 0; b < int'(BE_W); b++) begin
        if (be_i[b]) begin
          mem[addr_i][8*b +: 8] <= wdata_i[8*b +: 8];
        end
      end
    end
    if (re_i) begin
      rdata_q <= mem[addr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/avmm_image_responder.sv
// Never-stalling AVMM memory image with fixed read
// latency, poison on out-of-range and saturating stats.
module avmm_image_responder
  import avmm_pkg::*;
#(
  parameter int unsigned       DEPTH        = 4096,
  parameter logic [ADDR_W-1:0] BASE_ADDR    = '0,
  parameter int unsigned       READ_LATENCY = 1,
  parameter logic [DATA_W-1:0] POISON       = POISON_DEFAULT
) (
  input  logic  clock,
  input  logic  reset,
  avmm_image_responder_if.slave avmm_0_rw,
  output logic [31:0] rd_count,
  output logic [31:0] wr_count,
  output logic [15:0] err_count
);

  localparam int unsigned IW = $clog2(DEPTH);
  localparam int unsigned L  = READ_LATENCY;

  req_t req;

  assign req = '{
    address:    avmm_0_rw.address,
    byteenable: avmm_0_rw.byteenable,
    read:       avmm_0_rw.read,
    write:      avmm_0_rw.write,
    writedata:  avmm_0_rw.writedata
  };

  logic [ADDR_W-1:0] word;
  logic              in_rng;
  logic              misal;
  logic              rd_acc;
  logic              wr_acc;
  logic              err;

  always_comb begin
    word   = (req.address - BASE_ADDR) >> 3;
    in_rng = (req.address >= BASE_ADDR) &&
             (word < ADDR_W'(DEPTH));
    misal  = |req.address[2:0];
    wr_acc = !reset && req.write;
    // a simultaneous read is dropped in favour of the write
    rd_acc = !reset && req.read && !req.write;
    err    = !reset && (req.read || req.write) &&
             (!in_rng || misal ||
              (req.read && req.write));
  end

  logic [DATA_W-1:0] ram_rd;

  avmm_be_ram #(
    .DEPTH (DEPTH)
  ) u_ram (
    .clk_i   (clock),
    .we_i    (wr_acc && in_rng),
    .re_i    (rd_acc && in_rng),
    .addr_i  (word[IW-1:0]),
    .be_i    (req.byteenable),
    .wdata_i (req.writedata),
    .rdata_o (ram_rd)
  );

  logic [L-1:0]      tv_q, tv_d;
  logic              oor_q;
  logic [DATA_W-1:0] d0;
  logic [DATA_W-1:0] resp;
  logic              rvalid;
  logic [DATA_W-1:0] hold_q;

  logic [31:0] rd_cnt_q, rd_cnt_d;
  logic [31:0] wr_cnt_q, wr_cnt_d;
  logic [15:0] er_cnt_q, er_cnt_d;

  assign d0 = oor_q ? POISON : ram_rd;

  if (L == 1) begin : g_lat1
    assign resp = d0;
  end else begin : g_latn
    logic [DATA_W-1:0] dq_q [L-1];
    always_ff @(posedge clock) begin
      dq_q[0] <= d0;
      for (int i = 1; i < int'(L) - 1; i++) begin
        dq_q[i] <= dq_q[i-1];
      end
    end
    assign resp = dq_q[L-2];
  end

  always_comb begin
    tv_d     = (tv_q << 1) | L'(rd_acc);
    rd_cnt_d = sat_inc32(rd_cnt_q, rd_acc);
    wr_cnt_d = sat_inc32(wr_cnt_q, wr_acc);
    er_cnt_d = sat_inc16(er_cnt_q, err);
  end

  assign rvalid = tv_q[L-1];

  always_ff @(posedge clock) begin
    oor_q <= !in_rng;
    if (reset) begin
      tv_q     <= '0;
      hold_q   <= '0;
      rd_cnt_q <= '0;
      wr_cnt_q <= '0;
      er_cnt_q <= '0;
    end else begin
      tv_q     <= tv_d;
      rd_cnt_q <= rd_cnt_d;
      wr_cnt_q <= wr_cnt_d;
      er_cnt_q <= er_cnt_d;
      if (rvalid) begin
        hold_q <= resp;
      end
    end
  end

  assign avmm_0_rw.readdata      = rvalid ? resp : hold_q;
  assign avmm_0_rw.readdatavalid = rvalid;
  assign rd_count  = rd_cnt_q;
  assign wr_count  = wr_cnt_q;
  assign err_count = er_cnt_q;

endmodule
